// File: rtl/riscv_pkg.sv
// Shared constants and types for the RV32I core: opcodes, ALU operations and
// the memory arbiter's state and owner enumerations.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWNER_IF   = 1'b0,
        OWNER_DATA = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t       state;
    arb_state_t       next_state;
    arb_owner_t       owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_if;
    logic             grant_d;
    logic             ack_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grants are only made from IDLE, so requester inputs are ignored everywhere else.
    always_comb begin
        next_state = state;
        grant_if   = 1'b0;
        grant_d    = 1'b0;
        ack_seen   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req && d_req) begin
                    if (starve_cnt == CNT_MAX) begin
                        grant_if = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (if_req) begin
                    grant_if = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_if) begin
                    next_state = BUSY_IF;
                end else if (grant_d) begin
                    next_state = BUSY_D;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack) begin
                    ack_seen   = 1'b1;
                    next_state = RESP;
                end
            end
            RESP: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The ready pulse is registered on the ack edge so it lands in the RESP cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner     <= OWNER_IF;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (grant_if) begin
                owner     <= OWNER_IF;
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_be    <= 4'hF;
            end else if (grant_d) begin
                owner     <= OWNER_DATA;
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_be;
            end
            if (ack_seen) begin
                mem_req <= 1'b0;
                if (owner == OWNER_IF) begin
                    if_ready <= 1'b1;
                    if_rdata <= mem_rdata;
                end else begin
                    d_ready <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    // Counts data grants that jumped ahead of a waiting fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_d && if_req && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory commands and
// responses, a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_arbiter;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    logic ack_en;
    logic force_ack;

    typedef struct {
        logic        is_data;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } cmd_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    resp_t exp_resp[$];
    cmd_t  exp_cmd[$];
    chk_t  chk_q[$];
    int    n_vec;
    int    n_miss;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_2000: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Memory acks in the first cycle it sees mem_req, with data for the held address.
    always @(posedge clk) begin
        #1;
        mem_ack   = (mem_req && ack_en) || force_ack;
        mem_rdata = mem_model(mem_addr);
    end

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // Sole owner of the counters: drains direct checks and scores DUT outputs.
    always @(negedge clk) begin
        chk_t  c;
        resp_t r;
        cmd_t  m;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compare(c.name, c.act, c.exp);
        end
        if (mem_req && mem_ack) begin
            if (exp_cmd.size() == 0) begin
                compare("unexpected_mem_cmd", 32'd1, 32'd0);
            end else begin
                m = exp_cmd.pop_front();
                compare("mem_addr", mem_addr, m.addr);
                compare("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                compare("mem_be", {28'd0, mem_be}, {28'd0, m.be});
                if (m.we) begin
                    compare("mem_wdata", mem_wdata, m.wdata);
                end
            end
        end
        if (if_ready || d_ready) begin
            compare("single_ready", {31'd0, if_ready & d_ready}, 32'd0);
            if (exp_resp.size() == 0) begin
                compare("unexpected_ready", 32'd1, 32'd0);
            end else begin
                r = exp_resp.pop_front();
                compare("ready_owner", {31'd0, d_ready}, {31'd0, r.is_data});
                compare(d_ready ? "d_rdata" : "if_rdata", d_ready ? d_rdata : if_rdata, r.rdata);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic pushCmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input logic is_data, input logic [31:0] rdata);
        cmd_t  m;
        resp_t r;
        m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
        r.is_data = is_data; r.rdata = rdata;
        exp_cmd.push_back(m);
        exp_resp.push_back(r);
    endtask

    task automatic applyStimulus(input logic want_d, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(want_d ? d_ready : if_ready) && cycles < budget);
        if (!(want_d ? d_ready : if_ready)) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mem_req"},   {31'd0, mem_req}, 32'd0);
        checkOutput({tag, "_mem_we"},    {31'd0, mem_we}, 32'd0);
        checkOutput({tag, "_mem_addr"},  mem_addr, 32'd0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        checkOutput({tag, "_mem_be"},    {28'd0, mem_be}, 32'd0);
        checkOutput({tag, "_if_ready"},  {31'd0, if_ready}, 32'd0);
        checkOutput({tag, "_d_ready"},   {31'd0, d_ready}, 32'd0);
        checkOutput({tag, "_if_rdata"},  if_rdata, 32'd0);
        checkOutput({tag, "_d_rdata"},   d_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int nd;
        int total;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_be = '0; ack_en = 1'b1; force_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single fetch: ready must appear two cycles after the request is raised.
        if_addr = 32'h100; if_req = 1'b1;
        pushCmd(1'b0, 32'h100, 32'h0, 4'hF, 1'b0, 32'h0050_0093);
        applyStimulus(1'b0, 10, cyc);
        if_req = 1'b0;
        checkOutput("fetch_latency", cyc, 32'd2);

        // Simultaneous fetch and load: load first, fetch three cycles later.
        @(negedge clk);
        if_addr = 32'h104; if_req = 1'b1;
        d_addr = 32'h2000; d_we = 1'b0; d_wdata = '0; d_be = 4'hF; d_req = 1'b1;
        pushCmd(1'b0, 32'h2000, 32'h0, 4'hF, 1'b1, 32'hDEAD_BEEF);
        pushCmd(1'b0, 32'h104, 32'h0, 4'hF, 1'b0, 32'h00A0_0113);
        applyStimulus(1'b1, 10, cyc);
        d_req = 1'b0;
        applyStimulus(1'b0, 10, cyc);
        if_req = 1'b0;
        checkOutput("fetch_after_load_gap", cyc, 32'd3);

        // Store leaves d_rdata at the last load value.
        @(negedge clk);
        d_addr = 32'h3000; d_we = 1'b1; d_wdata = 32'h1234_5678; d_be = 4'b0011; d_req = 1'b1;
        pushCmd(1'b1, 32'h3000, 32'h1234_5678, 4'b0011, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 10, cyc);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        checkOutput("store_keeps_d_rdata", d_rdata, 32'hDEAD_BEEF);

        // Continuous data traffic: four data grants, then the starved fetch, then data again.
        @(negedge clk);
        if_addr = 32'h108; if_req = 1'b1;
        d_addr = 32'h4000; d_wdata = '0; d_be = 4'hF; d_req = 1'b1;
        pushCmd(1'b0, 32'h4000, 32'h0, 4'hF, 1'b1, 32'hA5A5_4000);
        pushCmd(1'b0, 32'h4004, 32'h0, 4'hF, 1'b1, 32'hA5A5_4004);
        pushCmd(1'b0, 32'h4008, 32'h0, 4'hF, 1'b1, 32'hA5A5_4008);
        pushCmd(1'b0, 32'h400C, 32'h0, 4'hF, 1'b1, 32'hA5A5_400C);
        pushCmd(1'b0, 32'h108,  32'h0, 4'hF, 1'b0, 32'hA5A5_0108);
        pushCmd(1'b0, 32'h4010, 32'h0, 4'hF, 1'b1, 32'hA5A5_4010);
        nd = 0; total = 0; cyc = 0;
        while (cyc < 60 && !(nd == 5 && !if_req)) begin
            @(negedge clk);
            cyc++;
            if (d_ready) begin
                nd++;
                total = cyc;
                if (nd == 5) d_req = 1'b0;
                else d_addr = d_addr + 32'd4;
            end
            if (if_ready) if_req = 1'b0;
        end
        d_req = 1'b0; if_req = 1'b0;
        checkOutput("starve_data_count", nd, 32'd5);
        checkOutput("starve_total_cycles", total, 32'd17);

        // Reset during a stalled load, then a stray ack: nothing may respond.
        @(negedge clk);
        ack_en = 1'b0;
        d_addr = 32'h5000; d_we = 1'b0; d_req = 1'b1;
        cyc = 0;
        while (!mem_req && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("stall_mem_req", {31'd0, mem_req}, 32'd1);
        checkOutput("stall_mem_addr", mem_addr, 32'h5000);
        repeat (2) @(negedge clk);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        rst = 1'b0; force_ack = 1'b1;
        repeat (2) @(negedge clk);
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkResetValues("midrst");
        ack_en = 1'b1;

        checkOutput("resp_queue_drained", exp_resp.size(), 32'd0);
        checkOutput("cmd_queue_drained", exp_cmd.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port if_req  input  1  instruction-fetch request, held until if_ready.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_ready  output  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-007 SHALL have port if_rdata  output  32  fetched instruction word.
REQ-008 SHALL have port d_req  input  1  data request (decoder mem_read or mem_write), held until d_ready.
REQ-009 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have port d_addr  input  32  data address (ALU result).
REQ-011 SHALL have port d_wdata  input  32  store data.
REQ-012 SHALL have port d_be  input  4  store byte enables.
REQ-013 SHALL have port d_ready  output  1  one-cycle pulse: data access complete.
REQ-014 SHALL have port d_rdata  output  32  load data, valid with d_ready.
REQ-015 SHALL have port mem_req  output  1  request to the single-port memory.
REQ-016 SHALL have port mem_we, mem_addr, mem_wdata, mem_be  output  1/32/32/4  registered memory command.
REQ-017 SHALL have port mem_ack  input  1  memory completion; mem_rdata valid in the same cycle.
REQ-018 SHALL have port mem_rdata  input  32  memory read data.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY_IF, BUSY_D and RESP.
REQ-020 IDLE: with no request pending, SHALL remain in IDLE.
REQ-021 IDLE, only one request pending: SHALL grant it.
REQ-022 IDLE, both requests pending: SHALL grant data, unless starve_cnt == STARVE_LIMIT, in which case SHALL grant fetch.
REQ-023 On grant SHALL latch the owner's command into the mem_* registers; fetch grants SHALL drive mem_we=0 and mem_be=4'hF.
REQ-024 SHALL assert mem_req from the cycle after grant and hold it, with the command stable, until mem_ack.
REQ-025 BUSY_IF/BUSY_D on mem_ack: SHALL drop mem_req next cycle, register mem_rdata into the owner's rdata, and enter RESP.
REQ-026 RESP: SHALL pulse exactly one of if_ready or d_ready for one cycle, then go to IDLE; no grant SHALL be made in RESP.
REQ-027 Minimum latency: request seen in IDLE at cycle N, mem_ack at N+1, ready at N+2, next arbitration at N+3.
REQ-028 if_rdata/d_rdata SHALL hold their last value until the next completion of the same owner.
REQ-029 d_rdata SHALL NOT be updated for stores.
REQ-030 starve_cnt SHALL increment on a data grant while if_req=1, saturate at STARVE_LIMIT, and clear on any fetch grant.
REQ-031 mem_ack in IDLE or RESP SHALL be ignored.
REQ-032 Requester inputs SHALL be ignored outside IDLE; changes mid-access SHALL have no effect.

Reset
REQ-033 rst SHALL force IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, if_ready=0, d_ready=0, if_rdata=0, d_rdata=0 at the next edge.
REQ-034 rst asserted mid-access SHALL abandon the access with no ready pulse; a subsequent mem_ack SHALL be ignored.

Structure
REQ-035 The state enum (arb_state_t) and owner enum (IF/DATA) SHALL live in the shared riscv_pkg alongside the existing opcode and ALU constants.
REQ-036 SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 Fetch only, if_addr=0x100, memory acks one cycle after mem_req with 0x00500093 -> mem_addr=0x100, mem_we=0; if_ready pulses once with if_rdata=0x00500093 at N+2.
REQ-038 Both requests in the same cycle, fetch 0x104, load 0x2000 returning 0xDEADBEEF -> load served first (d_rdata=0xDEADBEEF), then fetch; never two ready pulses in one cycle.
REQ-039 Store d_addr=0x3000, d_wdata=0x12345678, d_be=4'b0011 -> memory sees mem_we=1, be=0011; d_rdata unchanged; d_ready pulses once.
REQ-040 d_req held continuously with if_req pending, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant, then data resumes.
REQ-041 rst asserted while in BUSY_D with mem_ack withheld, then mem_ack pulsed after reset -> no d_ready, FSM stays IDLE, all outputs at reset values.
